// File: rtl/key_scan_scheduler.sv
// Four-key debouncer sharing one 1 ms timebase among all keys via a round-robin scheduler.
// Optional long-press detection is built when LONG_PRESS_EN is defined (adds Long_Pulse).
module key_scan_scheduler #(
    parameter logic [15:0] T1MS     = 16'd49_999,
    parameter logic [3:0]  DELAY_MS = 4'd10,
    parameter logic [10:0] LONG_MS  = 11'd1000
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [3:0] Key_In,
    output logic [3:0] Key_State,
    output logic [3:0] Press_Pulse,
    output logic [3:0] Release_Pulse,
`ifdef LONG_PRESS_EN
    output logic [3:0] Long_Pulse,
`endif
    output logic       Busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    logic [3:0]  sync1_q, sync1_d;
    logic [3:0]  sync_q, sync_d;
    logic [3:0]  prev_q, prev_d;
    logic [3:0]  pending_q, pending_d;
    logic [3:0]  key_edge;

    state_t      state_q;
    logic [1:0]  sel_q;
    logic [1:0]  rr_q;
    logic [15:0] count1_q;
    logic [3:0]  count_ms_q;
    logic [3:0]  key_state_q;
    logic [3:0]  press_q;
    logic [3:0]  release_q;
    logic        busy_q;

    logic        grant_vld;
    logic [1:0]  grant_idx;
    logic        c1_wrap;
    logic [3:0]  ms_next;

    assign key_edge = sync_q ^ prev_q;
    assign c1_wrap  = (count1_q == T1MS);
    assign ms_next  = count_ms_q + 4'd1;

    // Input conditioning and pending queue; a fresh edge in the CHECK cycle re-queues the key.
    always_comb begin
        sync1_d   = Key_In;
        sync_d    = sync1_q;
        prev_d    = sync_q;
        pending_d = pending_q;
        if (state_q == S_CHECK) begin
            pending_d[sel_q] = 1'b0;
        end
        pending_d = pending_d | key_edge;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync1_q   <= 4'b1111;
            sync_q    <= 4'b1111;
            prev_q    <= 4'b1111;
            pending_q <= 4'b0000;
        end else begin
            sync1_q   <= sync1_d;
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
        end
    end

    // Round-robin search: lowest offset from the pointer wins, so scan offsets high to low.
    always_comb begin
        logic [1:0] cand;
        grant_vld = 1'b0;
        grant_idx = rr_q;
        cand      = rr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = rr_q + 2'(k);
            if (pending_q[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= S_IDLE;
            sel_q       <= 2'd0;
            rr_q        <= 2'd0;
            count1_q    <= 16'd0;
            count_ms_q  <= 4'd0;
            key_state_q <= 4'b1111;
            press_q     <= 4'b0000;
            release_q   <= 4'b0000;
            busy_q      <= 1'b0;
        end else begin
            press_q   <= 4'b0000;
            release_q <= 4'b0000;
            case (state_q)
                S_IDLE: begin
                    if (grant_vld) begin
                        sel_q      <= grant_idx;
                        count1_q   <= 16'd0;
                        count_ms_q <= 4'd0;
                        state_q    <= S_WAIT;
                        busy_q     <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // Leave on the wrap that completes the last ms so WAIT is exactly DELAY_MS ms.
                    if (c1_wrap) begin
                        count1_q <= 16'd0;
                        if (ms_next == DELAY_MS) begin
                            count_ms_q <= 4'd0;
                            state_q    <= S_CHECK;
                        end else begin
                            count_ms_q <= ms_next;
                        end
                    end else begin
                        count1_q <= count1_q + 16'd1;
                    end
                end
                S_CHECK: begin
                    if (sync_q[sel_q] != key_state_q[sel_q]) begin
                        key_state_q[sel_q] <= sync_q[sel_q];
                        if (sync_q[sel_q]) begin
                            release_q[sel_q] <= 1'b1;
                        end else begin
                            press_q[sel_q] <= 1'b1;
                        end
                    end
                    rr_q    <= sel_q + 2'd1;
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Key_State     = key_state_q;
    assign Press_Pulse   = press_q;
    assign Release_Pulse = release_q;
    assign Busy          = busy_q;

`ifdef LONG_PRESS_EN
    logic [15:0]      tick_cnt_q, tick_cnt_d;
    logic [3:0][10:0] hold_q, hold_d;
    logic [3:0]       long_q, long_d;
    logic             tick;

    assign tick = (tick_cnt_q == T1MS);

    // Hold counters saturate at LONG_MS, so the pulse fires once per press.
    always_comb begin
        tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
        hold_d     = hold_q;
        long_d     = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (key_state_q[i]) begin
                hold_d[i] = 11'd0;
            end else if (tick && (hold_q[i] < LONG_MS)) begin
                hold_d[i] = hold_q[i] + 11'd1;
                long_d[i] = (hold_q[i] == LONG_MS - 11'd1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            tick_cnt_q <= 16'd0;
            hold_q     <= '0;
            long_q     <= 4'b0000;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            hold_q     <= hold_d;
            long_q     <= long_d;
        end
    end

    assign Long_Pulse = long_q;
`endif

endmodule

// File: doc/key_scan_scheduler.md
Name: key_scan_scheduler

Overview:
- Debounces four active-low push-buttons using one shared 1 ms timebase and one shared ms counter instead of one delay engine per key.
- A round-robin scheduler grants the timer to one key with a pending edge at a time. After DELAY_MS it re-samples that key and commits a debounced state change.
- Sits between the raw key pins and the downstream LED/control logic. Emits a level (Key_State) plus one-cycle press and release pulses.

Parameters:
- T1MS, 16'd49_999, cycles per 1 ms minus 1 (50 MHz clock).
- DELAY_MS, 4'd10, settle time in ms before re-sampling; legal range 1..15.
- LONG_MS, 11'd1000, long-press threshold in ms; used only with LONG_PRESS_EN.

Ports:
- CLK  input  1  system clock.
- RSTn  input  1  reset, asynchronous, active-low.
- Key_In  input  4  raw key pins, asynchronous, active-low (0 = pressed).
- Key_State  output  4  debounced key level, 0 = pressed.
- Press_Pulse  output  4  one-cycle pulse when a key's debounced state goes 1->0.
- Release_Pulse  output  4  one-cycle pulse when a key's debounced state goes 0->1.
- Busy  output  1  high while the scheduler is in WAIT or CHECK.

Behaviour:
- One clock (CLK). Reset is asynchronous and active-low (RSTn). Every register is cleared the instant RSTn goes low.
- Reset values:
  - Key_State = 4'b1111; 2-FF synchronisers and the previous-sample register = 4'b1111.
  - Press_Pulse = Release_Pulse = 0; Busy = 0.
  - Pending = 0; rr pointer = 0; Count1 = 0; Count_MS = 0; state = IDLE.
- Synchroniser: Key_In passes through 2 FFs to give sync.
- Edge detect: edge[i] = sync[i] XOR prev[i]. On edge[i], Pending[i] is set on the next clock.
- FSM states: IDLE, WAIT, CHECK.
  - IDLE:
    - If Pending is nonzero, search from rr pointer upward, wrapping 3->0, for the first set bit.
    - Latch that index into Sel, clear Count1 and Count_MS, and go to WAIT.
    - Otherwise stay in IDLE.
  - WAIT:
    - Count1 counts 0..T1MS then wraps.
    - On each wrap, Count_MS increments.
    - When Count_MS == DELAY_MS, go to CHECK. WAIT therefore lasts DELAY_MS*(T1MS+1) cycles.
    - Count1 and Count_MS hold at 0 outside WAIT.
  - CHECK (1 cycle):
    - If sync[Sel] != Key_State[Sel]: update Key_State[Sel], and assert Press_Pulse[Sel] (new value 0) or Release_Pulse[Sel] (new value 1) for exactly one cycle.
    - If sync[Sel] == Key_State[Sel], this is a bounce: no change and no pulse.
    - Clear Pending[Sel] unless edge[Sel] is high in this same cycle; set wins, so the key is re-queued.
    - Set rr pointer = Sel+1 mod 4, then go to IDLE.
- Busy = (state != IDLE).
- Edges on other keys during WAIT only set their Pending bits; no event is lost.
- Edges on the granted key during WAIT keep Pending[Sel] set. The key is therefore serviced again, and the final level always converges.
- Worst-case latency from a stable input change to the pulse: 3 sync/detect cycles, plus 4 services in the queue × (DELAY_MS*(T1MS+1)+2) cycles.
- Count_MS is 4 bits and never exceeds DELAY_MS, so there is no wrap hazard.

Optional Feature:
- Macro: LONG_PRESS_EN.
- Defined:
  - Adds output Long_Pulse[3:0] and a free-running 1 ms tick counter (independent of the shared timer).
  - Adds one 11-bit hold counter per key. The counter clears when Key_State[i] == 1 and increments on each tick while Key_State[i] == 0, saturating at LONG_MS.
  - Long_Pulse[i] is asserted for one cycle on the tick where the counter reaches LONG_MS. It fires only once per press.
  - Reset values: hold counters, tick counter and Long_Pulse all 0.
- Undefined: no Long_Pulse port and none of this logic; the other outputs are identical.

Test Plan (T1MS=9, DELAY_MS=2; WAIT = 20 cycles):
- Clean press: Key_In[0] 1->0 and held.
  - Busy rises 4 cycles later.
  - Press_Pulse[0] is high for 1 cycle about 24 cycles after the input change; Key_State = 4'b1110.
  - Release later: Release_Pulse[0] fires and Key_State returns to 4'b1111.
- Bounce rejection: Key_In[1] goes low for 5 cycles, then high.
  - One CHECK occurs with no pulse; Key_State stays 4'b1111.
  - Pending clears (the second edge is absorbed in the same service).
- Simultaneous: Key_In[3:0] = 4'b0000 at once, rr pointer = 0.
  - Press pulses appear in order 0,1,2,3, spaced 22 cycles apart.
  - Final Key_State = 4'b0000.
- Round-robin fairness: service key 2, then press keys 1 and 3 together.
  - Key 3 is granted before key 1 (pointer = 3).
- Reset mid-WAIT: drop RSTn during WAIT.
  - All outputs return immediately to their reset values; Busy = 0.
  - After release, nothing fires until a new edge.
- LONG_PRESS_EN with LONG_MS=5: hold Key_In[0] low.
  - Long_Pulse[0] fires once, 5 ticks (50 cycles) after Press_Pulse[0].
  - No repeat pulse while the key stays held.
